// File: rtl/axis_tpg_pkg.sv
// axis_tpg_pkg: mode/FSM encodings, tuser width and Galois LFSR tap masks for the test pattern generator
package axis_tpg_pkg;
  typedef enum logic [1:0] {MODE_RAMP, MODE_TRI, MODE_CONST, MODE_LFSR} mode_e;
  typedef enum logic {IDLE, SEND} fsm_e;
  function automatic int tuser_w(int n);
    return $clog2(n < 2 ? 2 : n);
  endfunction
  // right-shifting Galois masks, maximal length for each width
  function automatic logic [31:0] lfsr_taps(int w);
    case (w)
      8: return 32'h000000B8;
      9: return 32'h00000110;
      10: return 32'h00000240;
      11: return 32'h00000500;
      12: return 32'h00000829;
      13: return 32'h0000100D;
      14: return 32'h00002015;
      15: return 32'h00006000;
      16: return 32'h0000D008;
      17: return 32'h00012000;
      18: return 32'h00020400;
      19: return 32'h00040023;
      20: return 32'h00090000;
      21: return 32'h00140000;
      22: return 32'h00300000;
      23: return 32'h00420000;
      24: return 32'h00E10000;
      25: return 32'h01200000;
      26: return 32'h02000023;
      27: return 32'h04000013;
      28: return 32'h09000000;
      29: return 32'h14000000;
      30: return 32'h20000029;
      31: return 32'h48000000;
      default: return 32'h80200003;
    endcase
  endfunction
endpackage

// File: rtl/axis_testpattern_generator_mc_if.sv
// axis_testpattern_generator_mc_if: AXI-Stream bus with channel index in tuser
interface axis_testpattern_generator_mc_if #(parameter int W = 24, parameter int UW = 1) ();
  logic [W-1:0] tdata;
  logic [UW-1:0] tuser;
  logic tvalid;
  logic tready;
  logic tlast;
  modport master(output tdata, tuser, tvalid, tlast, input tready);
  modport slave(input tdata, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/axis_testpattern_generator_mc_core.sv
// tpg_pattern_core: pattern value, triangle direction and last-frame mode; fval is the value for a frame starting now
module tpg_pattern_core import axis_tpg_pkg::*; #(
  parameter int W = 24,
  parameter int unsigned COUNTER_START = 1,
  parameter int unsigned COUNTER_END = 10,
  parameter int unsigned COUNTER_INCR = 1
) (
  input logic clk,
  input logic rst_n,
  input logic start,
  input logic adv,
  input mode_e mode,
  output logic [W-1:0] fval
);
  localparam logic [W:0] S = (W+1)'(COUNTER_START);
  localparam logic [W:0] E = (W+1)'(COUNTER_END);
  localparam logic [W:0] INC = (W+1)'(COUNTER_INCR);
  localparam logic [W-1:0] TAPS = W'(lfsr_taps(W));
  localparam logic [W-1:0] SEED = (W'(COUNTER_START) == '0) ? W'(1) : W'(COUNTER_START);
  logic [W-1:0] value, value_n, stepv, dn;
  logic [W:0] up_s;
  logic down, down_n, step_down, flip, restart;
  mode_e last_mode;
  // ramp/triangle bounds are compared in W+1 bits so END near 2^W-1 cannot wrap
  always_comb begin
    up_s = {1'b0, value} + INC;
    dn = value - INC[W-1:0];
    flip = down ? ({1'b0, value} < S + INC) : (up_s > E);
    step_down = down;
    stepv = value;
    unique case (last_mode)
      MODE_RAMP: stepv = up_s > E ? S[W-1:0] : up_s[W-1:0];
      MODE_TRI: begin
        step_down = down ^ flip;
        stepv = step_down ? dn : up_s[W-1:0];
      end
      MODE_CONST: stepv = S[W-1:0];
      default: stepv = (value >> 1) ^ (value[0] ? TAPS : '0);
    endcase
    restart = start && mode != last_mode;
    value_n = restart ? (mode == MODE_LFSR ? SEED : S[W-1:0]) : adv ? stepv : value;
    down_n = restart ? 1'b0 : adv ? step_down : down;
  end
  assign fval = value_n;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= S[W-1:0];
      down <= 1'b0;
      last_mode <= MODE_RAMP;
    end else begin
      value <= value_n;
      down <= down_n;
      if (start) last_mode <= mode;
    end
  end
endmodule

// File: rtl/axis_testpattern_generator_mc.sv
// axis_testpattern_generator_mc: divider-paced multi-channel AXI-Stream pattern source with overrun flag
module axis_testpattern_generator_mc import axis_tpg_pkg::*; #(
  parameter int TDATA_WIDTH = 24,
  parameter int NUM_CHANNELS = 2,
  parameter int unsigned COUNTER_START = 1,
  parameter int unsigned COUNTER_END = 10,
  parameter int unsigned COUNTER_INCR = 1,
  parameter int DIVIDER = 3,
  parameter int unsigned CHANNEL_OFFSET = 0
) (
  input logic m_axis_aclk,
  input logic m_axis_aresetn,
  input logic enable,
  input logic [1:0] mode,
  output logic overrun,
  axis_testpattern_generator_mc_if.master m_axis
);
  localparam int W = TDATA_WIDTH;
  localparam int UW = tuser_w(NUM_CHANNELS);
  localparam int DW = $clog2(DIVIDER < 2 ? 2 : DIVIDER);
  fsm_e state, state_n;
  logic [DW-1:0] div_cnt;
  logic [W-1:0] fval;
  logic [UW-1:0] nxt_ch;
  logic tick, accept, last_acc, start;
  assign tick = enable && div_cnt == DW'(DIVIDER - 1);
  always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
    if (!m_axis_aresetn) begin
      div_cnt <= '0;
      state <= IDLE;
    end else begin
      div_cnt <= (!enable || tick) ? '0 : div_cnt + 1'b1;
      state <= state_n;
    end
  end
  // a tick landing on the final accept chains straight into the next frame
  always_comb begin
    accept = m_axis.tvalid && m_axis.tready;
    last_acc = accept && m_axis.tlast;
    start = tick && (state == IDLE || last_acc);
    nxt_ch = start ? '0 : m_axis.tuser + 1'b1;
    state_n = start ? SEND : last_acc ? IDLE : state;
  end
  tpg_pattern_core #(.W(W), .COUNTER_START(COUNTER_START), .COUNTER_END(COUNTER_END),
    .COUNTER_INCR(COUNTER_INCR)) u_core (
    .clk(m_axis_aclk), .rst_n(m_axis_aresetn), .start(start), .adv(last_acc),
    .mode(mode_e'(mode)), .fval(fval));
  always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
    if (!m_axis_aresetn) begin
      m_axis.tvalid <= 1'b0;
      m_axis.tdata <= '0;
      m_axis.tuser <= '0;
      m_axis.tlast <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (start || (accept && !m_axis.tlast)) begin
        m_axis.tvalid <= 1'b1;
        m_axis.tuser <= nxt_ch;
        m_axis.tlast <= nxt_ch == UW'(NUM_CHANNELS - 1);
        m_axis.tdata <= fval + W'(CHANNEL_OFFSET) * W'(nxt_ch);
      end else if (accept) begin
        m_axis.tvalid <= 1'b0;
      end
      overrun <= enable && (overrun || (tick && state == SEND && !last_acc));
    end
  end
endmodule

// File: doc/axis_testpattern_generator_mc.md
# axis_testpattern_generator_mc

Multi-channel, multi-mode AXI-Stream test pattern source; parametrised successor of the single-channel counter generator. On each divider tick it produces one frame of NUM_CHANNELS beats carrying a ramp, triangle, constant or LFSR pattern. The frame is tagged per beat with the channel index and marked with tlast. It sits at the head of DAC/DSP stream chains for bring-up and regression.

## Interface
- TDATA_WIDTH, 24: data width W, 8..32.
- NUM_CHANNELS, 2: beats per frame, 1..16.
- COUNTER_START, 1: pattern start value; also LFSR seed (0 is replaced by 1).
- COUNTER_END, 10: ramp/triangle upper bound; START <= END.
- COUNTER_INCR, 1: step, >= 1; triangle mode requires END-START >= INCR.
- DIVIDER, 3: clock cycles per tick, >= 1.
- CHANNEL_OFFSET, 0: added per channel index to the frame value.
- m_axis_aclk  in  1  clock, sole clock domain.
- m_axis_aresetn  in  1  asynchronous, active-low reset.
- enable  in  1  run/stop.
- mode  in  2  0 ramp, 1 triangle, 2 constant, 3 LFSR.
- m_axis_tdata  out  W  sample.
- m_axis_tvalid  out  1  beat valid.
- m_axis_tready  in  1  sink ready.
- m_axis_tlast  out  1  last beat of frame.
- m_axis_tuser  out  clog2(max(NUM_CHANNELS,2))  channel index of beat.
- overrun  out  1  sticky: a tick was dropped.

## Operation
- Divider counter runs 0..DIVIDER-1 while enable=1; tick when it wraps; held at 0 while enable=0.
- FSM: IDLE -> SEND on tick; in SEND, beat c (0..N-1) is presented with tdata = value + c*CHANNEL_OFFSET (mod 2^W), tuser = c, tlast = (c == N-1).
- Beat advances only on tvalid & tready; tdata/tuser/tlast stay stable while tvalid=1 and tready=0.
- After the last beat is accepted: pattern value advances once, FSM -> IDLE (or straight to SEND if a tick coincides with that accept).
- Tick while in SEND (other than the final-accept cycle): tick dropped, overrun set; pattern is not advanced for dropped ticks.
- overrun is cleared by reset or by enable=0.
- mode is sampled at frame start. If it differs from the previous frame's mode, value restarts at START (LFSR: seed), and the triangle direction resets to up.
- Ramp: next = value+INCR, or START if value+INCR > END.
- Triangle: up until value+INCR > END, then down; down until value-INCR < START, then up. A reversal steps in the new direction on the same update.
- Constant: value = START.
- LFSR: Galois, maximal-length taps for W.
- Ramp/triangle arithmetic uses W+1 bits, so no overflow at END near 2^W-1.
- enable falling mid-frame: the frame completes; no truncation.

## Timing
- Reset values: tvalid 0, tdata 0, tlast 0, tuser 0, overrun 0, value START, direction up, divider 0, FSM IDLE.
- Reset asserted mid-frame clears everything immediately (async); the partial frame is lost.
- First tick comes DIVIDER cycles after enable=1 with reset released. tvalid rises the cycle after the tick (registered outputs).
- With tready=1, a frame takes NUM_CHANNELS cycles. DIVIDER < NUM_CHANNELS overruns by design.
- tready has no combinational path to any output.

## Structure
- Package axis_tpg_pkg: mode encodings; LFSR tap constant function for W=8..32.
- Sub-module tpg_pattern_core: holds value/direction/last-mode and computes the next value on an advance strobe. The top holds the divider, FSM, channel counter and AXIS register.

## Test plan
- W=24, N=2, START=1, END=10, INCR=1, DIV=3, ramp, tready=1 → frames (1,1),(2,2)…(10,10),(1,1); tuser 0,1; tlast on beat 1; frame every 3 cycles; overrun stays 0.
- Triangle, START=1, END=4, INCR=1 → values 1,2,3,4,3,2,1,2.
- tready low for 300 ns mid-frame → tdata/tuser/tlast frozen, overrun=1, no value skipped after release.
- Async reset pulse mid-frame → all outputs zero within the reset, restart at START with tuser=0.
- Mode change ramp→LFSR at value 7 → next frame starts at the seed. W=8 LFSR period 255 with no zero state.
- enable dropped mid-frame → the current frame completes, no further tvalid, overrun clears; re-enable → first beat DIVIDER+1 cycles later.
